breath_duty_ramp: RTL
=====================

Name: breath_duty_ramp

Overview:
Upstream stage of the breathing-light PWM (`led`/`check` block). It generates the duty-cycle word that rises and falls in a triangle with plateaus, producing one "breath" per cycle. The duty word changes only on PWM period boundaries, reported by the PWM stage via `pwm_period_end`, so the LED waveform never glitches mid-period. It also flags each completed breath for the downstream check logic.

Parameters:
- DUTY_W, 8, width of the duty word.
- DUTY_MAX, 255, peak duty value; must be ≤ 2^DUTY_W-1 and > 0.
- STEP, 1, duty increment/decrement per ramp step; must be ≥ 1.
- PERIODS_PER_STEP, 4, PWM periods per ramp step; must be ≥ 1.
- HOLD_PERIODS, 16, PWM periods held at peak and at trough; 0 means no plateau.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  enable; while 0 the block idles with duty 0.
- pwm_period_end  in  1  one-clk pulse from the PWM stage at each period boundary.
- duty  out  DUTY_W  duty word to the PWM comparator (registered).
- dir  out  1  1 = RISE/HOLD_HI, 0 = otherwise (registered).
- cycle_done  out  1  one-clk pulse when a full breath completes (registered).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, duty=0, dir=0, cycle_done=0, period counter=0. rst has priority over every other input.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO. Period counter `pc` is wide enough for max(PERIODS_PER_STEP, HOLD_PERIODS).
- IDLE: duty=0. en=1 → RISE next cycle with pc=0. pwm_period_end is ignored in IDLE.
- en=0 in any state → IDLE next cycle, duty=0, pc=0, no cycle_done. This is an abrupt stop, not a graceful ramp-down.
- RISE: each pwm_period_end increments pc.
  - On the pulse where pc==PERIODS_PER_STEP-1: pc←0 and duty←min(duty+STEP, DUTY_MAX).
  - The add is computed DUTY_W+1 bits wide, so it never wraps.
  - If the new duty==DUTY_MAX: go to HOLD_HI, or straight to FALL if HOLD_PERIODS==0.
- HOLD_HI: count HOLD_PERIODS pwm_period_end pulses, then FALL with pc=0. duty stays at DUTY_MAX.
- FALL: mirror of RISE. duty←max(duty-STEP, 0) using a saturating subtract. At 0, go to HOLD_LO, or straight to RISE if HOLD_PERIODS==0.
- HOLD_LO: after HOLD_PERIODS pulses → RISE. cycle_done=1 for exactly one clk, on the same edge where the RISE transition registers.
  - With HOLD_PERIODS==0, cycle_done fires on the FALL→RISE edge.
- Latency: duty, dir and the state update on the clk edge that samples the qualifying pwm_period_end pulse (1 clk after the pulse is asserted).
- pwm_period_end held high for several clks counts once per clk. Callers must pulse it.
- Simultaneous en falling edge and pwm_period_end: en wins, giving IDLE.
- dir is derived from the next state: 1 in RISE/HOLD_HI, 0 in IDLE/FALL/HOLD_LO.

Optional Feature:
- Macro BREATH_GAMMA_EN.
- When defined:
  - duty = registered perceptual map of the linear ramp value lin: (lin*lin)>>DUTY_W, with lin==DUTY_MAX forced to DUTY_MAX.
  - The map adds 1 clk of latency. dir and cycle_done are delayed by the same 1 clk to stay aligned.
  - Reset clears the pipeline register to 0.
- When undefined: duty = lin directly, with no extra stage.

Test Plan:
All scenarios use DUTY_W=4, DUTY_MAX=15, STEP=4, PERIODS_PER_STEP=2, HOLD_PERIODS=3, with pwm_period_end pulsed every 8 clks.
1. Reset for 5 clks, en=0, pulses running → duty=0, dir=0, cycle_done=0 throughout.
2. en=1 → duty sequence 0,4,8,12,15 (changes every 2nd pulse) with dir=1. Then 15 holds for 3 pulses, then 11,7,3,0 with dir=0, then a 3-pulse hold. cycle_done is a single 1-clk pulse after pulse 22. The sequence repeats identically on the second breath.
3. en dropped while duty=8 in RISE → next clk duty=0, state IDLE, no cycle_done. Re-enable → restart from 0.
4. rst asserted during HOLD_HI (duty=15) → next clk all outputs 0. After release with en=1, the ramp restarts at 0.
5. pwm_period_end held high for 4 consecutive clks in RISE from duty=0 → counts 4 periods, duty=8 afterwards. HOLD_PERIODS=0 build: 15 is followed directly by 11 on the next step.
6. BREATH_GAMMA_EN defined → duty sequence 0,1,4,9,15. Each value appears 1 clk later than in scenario 2, and cycle_done is shifted by 1 clk.

Source files
------------

// File: rtl/breath_duty_ramp.sv
// breath_duty_ramp: triangle-with-plateaus duty ramp for a breathing-light PWM, one "breath" per cycle.
// Ports: clk, rst (sync, active-high), en, pwm_period_end (period-boundary pulse) -> duty, dir, cycle_done.
// Latency/backpressure: outputs registered 1 clk after the qualifying pulse (+1 clk with BREATH_GAMMA_EN); no backpressure.
// Optional macro BREATH_GAMMA_EN: adds a registered perceptual (squared) map on duty and delays dir/cycle_done to match.
module breath_duty_ramp #(
  parameter int DUTY_W           = 8,
  parameter int DUTY_MAX         = 255,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4,
  parameter int HOLD_PERIODS     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_period_end,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic              cycle_done
);

  localparam int PC_MAX    = (PERIODS_PER_STEP > HOLD_PERIODS) ? PERIODS_PER_STEP : HOLD_PERIODS;
  localparam int PCW       = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;
  // HOLD states are unreachable when HOLD_PERIODS==0; keep the compare constant legal.
  localparam int HOLD_LAST = (HOLD_PERIODS > 0) ? HOLD_PERIODS - 1 : 0;

  localparam logic [DUTY_W:0]   STEP_W   = STEP[DUTY_W:0];
  localparam logic [DUTY_W:0]   DMAX_W   = DUTY_MAX[DUTY_W:0];
  localparam logic [DUTY_W-1:0] DMAX     = DUTY_MAX[DUTY_W-1:0];
  localparam logic [PCW-1:0]    STEP_END = PCW'(PERIODS_PER_STEP - 1);
  localparam logic [PCW-1:0]    HOLD_END = PCW'(HOLD_LAST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_HOLD_HI,
    S_FALL,
    S_HOLD_LO
  } state_t;

  state_t            state_q, state_d;
  logic [PCW-1:0]    pc_q, pc_d;
  logic [DUTY_W-1:0] lin_q, lin_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;

  logic [DUTY_W:0]   sum_w;
  logic [DUTY_W-1:0] inc_v;
  logic [DUTY_W-1:0] dec_v;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lin_d   = lin_q;
    done_d  = 1'b0;

    // One extra bit on the add so a step past DUTY_MAX saturates instead of wrapping.
    sum_w = {1'b0, lin_q} + STEP_W;
    inc_v = (sum_w >= DMAX_W) ? DMAX : sum_w[DUTY_W-1:0];
    dec_v = ({1'b0, lin_q} <= STEP_W) ? '0 : (lin_q - STEP_W[DUTY_W-1:0]);

    if (!en) begin
      // Abrupt stop: no ramp-down, no breath credit.
      state_d = S_IDLE;
      pc_d    = '0;
      lin_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_RISE;
          pc_d    = '0;
          lin_d   = '0;
        end
        S_RISE: if (pwm_period_end) begin
          if (pc_q == STEP_END) begin
            pc_d  = '0;
            lin_d = inc_v;
            if (inc_v == DMAX) state_d = (HOLD_PERIODS == 0) ? S_FALL : S_HOLD_HI;
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        S_HOLD_HI: if (pwm_period_end) begin
          if (pc_q == HOLD_END) begin
            pc_d    = '0;
            state_d = S_FALL;
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        S_FALL: if (pwm_period_end) begin
          if (pc_q == STEP_END) begin
            pc_d  = '0;
            lin_d = dec_v;
            if (dec_v == '0) begin
              if (HOLD_PERIODS == 0) begin
                state_d = S_RISE;
                done_d  = 1'b1;
              end else begin
                state_d = S_HOLD_LO;
              end
            end
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        S_HOLD_LO: if (pwm_period_end) begin
          if (pc_q == HOLD_END) begin
            pc_d    = '0;
            state_d = S_RISE;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          pc_d    = '0;
          lin_d   = '0;
        end
      endcase
    end

    dir_d = (state_d == S_RISE) || (state_d == S_HOLD_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lin_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lin_q   <= lin_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

`ifdef BREATH_GAMMA_EN
  logic [2*DUTY_W-1:0] sq_w;
  logic [DUTY_W-1:0]   gam_w;
  logic [DUTY_W-1:0]   duty_q;
  logic                dir2_q;
  logic                done2_q;

  // Squared map keeps low duty dim; the peak is pinned so the top of the breath still reaches DUTY_MAX.
  always_comb begin
    sq_w  = {{DUTY_W{1'b0}}, lin_q} * {{DUTY_W{1'b0}}, lin_q};
    gam_w = (lin_q == DMAX) ? DMAX : DUTY_W'(sq_w >> DUTY_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q  <= '0;
      dir2_q  <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      duty_q  <= gam_w;
      dir2_q  <= dir_q;
      done2_q <= done_q;
    end
  end

  assign duty       = duty_q;
  assign dir        = dir2_q;
  assign cycle_done = done2_q;
`else
  assign duty       = lin_q;
  assign dir        = dir_q;
  assign cycle_done = done_q;
`endif

endmodule
